// File: rtl/patch_row_reducer_n.sv
// Patch row reducer: matches one configured patch row in a multi-lane pixel stream
// and accumulates the weighted dot product through a 3-stage pipeline.
module patch_row_reducer_n #(
    parameter int PATCH_SIZE      = 8,
    parameter int N_PIXEL_PER_CLK = 2,
    parameter int N_COL_SIZE      = 12,
    parameter int N_ROW_SIZE      = 11,
    parameter int PIX_W           = 16,
    parameter int WGT_W           = 16,
    parameter int ACC_W           = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic                          abort,
    input  logic [N_ROW_SIZE-1:0]         conf_row,
    input  logic [N_COL_SIZE-1:0]         conf_col,
    input  logic [PATCH_SIZE*WGT_W-1:0]   conf_weights,
    output logic                          available,
    input  logic                          pix_val,
    input  logic [N_ROW_SIZE-1:0]         cur_row,
    input  logic [N_COL_SIZE-1:0]         l_col,
    input  logic [N_PIXEL_PER_CLK*PIX_W-1:0] pix,
    output logic [ACC_W-1:0]              sum,
    output logic                          sum_valid,
    input  logic                          sum_ack,
    output logic                          err
);
    localparam int PROD_W = PIX_W + WGT_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(N_PIXEL_PER_CLK);
    localparam int COL_XW = N_COL_SIZE + 1;
    localparam logic [N_COL_SIZE-1:0] ALIGN_MASK = ~N_COL_SIZE'(N_PIXEL_PER_CLK - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MATCH_WAIT = 3'd1,
        S_ACCUM      = 3'd2,
        S_DRAIN      = 3'd3,
        S_RESULT     = 3'd4
    } state_t;

    state_t                        state_r, state_next_s;
    logic [N_ROW_SIZE-1:0]         conf_row_r;
    logic [N_COL_SIZE-1:0]         conf_col_r, end_col_r, exp_col_r;
    logic [PATCH_SIZE*WGT_W-1:0]   conf_w_r;
    logic [1:0]                    drain_cnt_r;
    logic                          v1_r, v2_r;
    logic signed [PROD_W-1:0]      prod_r [N_PIXEL_PER_CLK];
    logic signed [SUM_W-1:0]       lane_sum_r;
    logic [ACC_W-1:0]              acc_r, sum_r;
    logic                          sum_valid_r, err_r, available_r;

    logic                          row_hit_s, first_hit_s, cont_ok_s, last_s;
    logic                          accept_s, err_s, load_s, flush_s, finish_s, ack_s;
    logic [COL_XW-1:0]             lane_col_s [N_PIXEL_PER_CLK];
    logic [COL_XW-1:0]             lane_off_s [N_PIXEL_PER_CLK];
    logic                          lane_act_s [N_PIXEL_PER_CLK];
    logic signed [WGT_W-1:0]       lane_w_s   [N_PIXEL_PER_CLK];
    logic signed [PROD_W-1:0]      prod_s     [N_PIXEL_PER_CLK];
    logic signed [SUM_W-1:0]       lane_sum_s;

    assign row_hit_s   = pix_val && (cur_row == conf_row_r);
    assign first_hit_s = row_hit_s && (l_col == (conf_col_r & ALIGN_MASK));
    assign cont_ok_s   = row_hit_s && (l_col == exp_col_r);
    assign last_s      = (l_col == (end_col_r & ALIGN_MASK));

    // Next-state and control decode; abort overrides every non-IDLE transition.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        err_s        = 1'b0;
        load_s       = 1'b0;
        flush_s      = 1'b0;
        finish_s     = 1'b0;
        ack_s        = 1'b0;
        if (abort && (state_r != S_IDLE)) begin
            state_next_s = S_IDLE;
            flush_s      = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (init) begin
                        load_s       = 1'b1;
                        state_next_s = S_MATCH_WAIT;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_MATCH_WAIT: begin
                    if (first_hit_s) begin
                        accept_s     = 1'b1;
                        state_next_s = last_s ? S_DRAIN : S_ACCUM;
                    end else begin
                        state_next_s = S_MATCH_WAIT;
                    end
                end
                S_ACCUM: begin
                    if (!pix_val) begin
                        state_next_s = S_ACCUM;
                    end else if (cont_ok_s) begin
                        accept_s     = 1'b1;
                        state_next_s = last_s ? S_DRAIN : S_ACCUM;
                    end else begin
                        err_s        = 1'b1;
                        flush_s      = 1'b1;
                        state_next_s = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_r == 2'd2) begin
                        finish_s     = 1'b1;
                        state_next_s = S_RESULT;
                    end else begin
                        state_next_s = S_DRAIN;
                    end
                end
                S_RESULT: begin
                    if (sum_ack) begin
                        ack_s        = 1'b1;
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_RESULT;
                    end
                end
                default: begin
                    flush_s      = 1'b1;
                    state_next_s = S_IDLE;
                end
            endcase
        end
    end

    // Per-lane window test, weight select and signed product.
    always_comb begin
        for (int k = 0; k < N_PIXEL_PER_CLK; k++) begin
            lane_col_s[k] = COL_XW'(l_col) + COL_XW'(k);
            lane_off_s[k] = lane_col_s[k] - {1'b0, conf_col_r};
            lane_act_s[k] = (lane_col_s[k] >= {1'b0, conf_col_r}) &&
                            (lane_col_s[k] <= {1'b0, end_col_r});
            lane_w_s[k]   = '0;
            for (int i = 0; i < PATCH_SIZE; i++) begin
                lane_w_s[k] = (lane_act_s[k] && (lane_off_s[k] == COL_XW'(i)))
                            ? $signed(conf_w_r[i*WGT_W +: WGT_W]) : lane_w_s[k];
            end
            prod_s[k] = PROD_W'($signed({1'b0, pix[k*PIX_W +: PIX_W]})) * PROD_W'(lane_w_s[k]);
        end
    end

    // Adder tree over the registered lane products.
    always_comb begin
        lane_sum_s = '0;
        for (int k = 0; k < N_PIXEL_PER_CLK; k++) begin
            lane_sum_s = lane_sum_s + SUM_W'(prod_r[k]);
        end
    end

    // FSM state, configuration, stream tracking and drain timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            available_r <= 1'b1;
            err_r       <= 1'b0;
            conf_row_r  <= '0;
            conf_col_r  <= '0;
            end_col_r   <= '0;
            conf_w_r    <= '0;
            exp_col_r   <= '0;
            drain_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_next_s;
            available_r <= (state_next_s == S_IDLE);
            err_r       <= err_s;
            if (load_s) begin
                conf_row_r <= conf_row;
                conf_col_r <= conf_col;
                end_col_r  <= conf_col + N_COL_SIZE'(PATCH_SIZE - 1);
                conf_w_r   <= conf_weights;
            end
            if (accept_s) begin
                exp_col_r   <= l_col + N_COL_SIZE'(N_PIXEL_PER_CLK);
                drain_cnt_r <= 2'd0;
            end else if (state_r == S_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + 2'd1;
            end
        end
    end

    // Datapath pipeline: products, lane sum, wrapping accumulator, held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            lane_sum_r  <= '0;
            acc_r       <= '0;
            sum_r       <= '0;
            sum_valid_r <= 1'b0;
            for (int k = 0; k < N_PIXEL_PER_CLK; k++) begin
                prod_r[k] <= '0;
            end
        end else begin
            v1_r <= accept_s;
            v2_r <= v1_r && !flush_s;
            if (accept_s) begin
                for (int k = 0; k < N_PIXEL_PER_CLK; k++) begin
                    prod_r[k] <= prod_s[k];
                end
            end
            if (v1_r) begin
                lane_sum_r <= lane_sum_s;
            end
            if (load_s) begin
                acc_r <= '0;
            end else if (v2_r && !flush_s) begin
                acc_r <= acc_r + {{(ACC_W-SUM_W){lane_sum_r[SUM_W-1]}}, lane_sum_r};
            end
            if (flush_s || ack_s) begin
                sum_valid_r <= 1'b0;
            end else if (finish_s) begin
                sum_valid_r <= 1'b1;
                sum_r       <= acc_r;
            end
        end
    end

    assign available = available_r;
    assign sum       = sum_r;
    assign sum_valid = sum_valid_r;
    assign err       = err_r;

endmodule
